// File: rtl/telem_pkg.sv
// Shared types and constants for the telemetry receive path.
// TELEM_CHKSUM_EN adds the trailing checksum byte and the CHK framer state.
package telem_pkg;

    localparam logic [7:0]  DELIM1        = 8'hAA;
    localparam logic [7:0]  DELIM2        = 8'h55;
    localparam int unsigned PAYLOAD_BYTES = 6;
    localparam int unsigned VAL_W         = 12;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

`ifdef TELEM_CHKSUM_EN
    typedef enum logic [1:0] {
        WAIT_AA,
        WAIT_55,
        PAYLOAD,
        CHK
    } frm_state_t;
`else
    typedef enum logic [1:0] {
        WAIT_AA,
        WAIT_55,
        PAYLOAD
    } frm_state_t;
`endif

    typedef struct packed {
        logic [VAL_W-1:0] batt;
        logic [VAL_W-1:0] curr;
        logic [VAL_W-1:0] torque;
    } telem_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle
// byte_rdy / frm_err pulses. A start edge is only accepted from a line seen high after reset.
module uart_rx_byte #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_rdy,
    output logic [7:0] byte_data,
    output logic       frm_err
);
    import telem_pkg::*;

    localparam int unsigned HALF  = BAUD_DIV / 2;
    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic             sync1;
    logic             sync2;
    logic             rx_prev;
    logic [1:0]       fill;
    logic             fall_c;

    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             byte_rdy_nxt;
    logic             frm_err_nxt;

    // fill marks when sync2 holds a real line sample rather than the reset preset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            fill    <= 2'b00;
            rx_prev <= 1'b0;
        end else begin
            sync1   <= rx;
            sync2   <= sync1;
            fill    <= {fill[0], 1'b1};
            rx_prev <= fill[1] & sync2;
        end
    end

    assign fall_c = fill[1] & rx_prev & ~sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_rdy <= 1'b0;
            frm_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_idx_nxt;
            shreg    <= shreg_nxt;
            byte_rdy <= byte_rdy_nxt;
            frm_err  <= frm_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        bit_idx_nxt  = bit_idx;
        shreg_nxt    = shreg;
        byte_rdy_nxt = 1'b0;
        frm_err_nxt  = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (fall_c) state_nxt = START;
            end
            START: begin
                if (cnt == CNT_W'(HALF - 1)) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_nxt     = '0;
                    shreg_nxt   = {sync2, shreg[7:1]};
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == CNT_W'(BAUD_DIV - 1)) begin
                    cnt_nxt      = '0;
                    state_nxt    = IDLE;
                    byte_rdy_nxt = sync2;
                    frm_err_nxt  = ~sync2;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign byte_data = shreg;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: frames AA 55 + six payload bytes into batt/curr/torque.
// TELEM_CHKSUM_EN: a ninth byte carries the mod-256 sum of the payload.
module telemetry_rx #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RX,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        pkt_vld,
    output logic        pkt_err
);
    import telem_pkg::*;

    logic       byte_rdy;
    logic [7:0] byte_data;
    logic       frm_err;

    uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (RX),
        .byte_rdy  (byte_rdy),
        .byte_data (byte_data),
        .frm_err   (frm_err)
    );

    frm_state_t frm, frm_nxt;
    logic [2:0] idx, idx_nxt;
    telem_t     shadow, shadow_nxt;
    logic       commit_c;
    logic       abort_c;
`ifdef TELEM_CHKSUM_EN
    logic [7:0] sum, sum_nxt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            frm     <= WAIT_AA;
            idx     <= '0;
            shadow  <= '0;
            batt    <= '0;
            curr    <= '0;
            torque  <= '0;
            pkt_vld <= 1'b0;
            pkt_err <= 1'b0;
`ifdef TELEM_CHKSUM_EN
            sum     <= '0;
`endif
        end else begin
            frm     <= frm_nxt;
            idx     <= idx_nxt;
            shadow  <= shadow_nxt;
            pkt_vld <= commit_c;
            pkt_err <= abort_c;
            if (commit_c) begin
                batt   <= shadow_nxt.batt;
                curr   <= shadow_nxt.curr;
                torque <= shadow_nxt.torque;
            end
`ifdef TELEM_CHKSUM_EN
            sum     <= sum_nxt;
`endif
        end
    end

    always_comb begin
        frm_nxt    = frm;
        idx_nxt    = idx;
        shadow_nxt = shadow;
        commit_c   = 1'b0;
        abort_c    = 1'b0;
`ifdef TELEM_CHKSUM_EN
        sum_nxt    = sum;
`endif
        if (frm_err) begin
            // a broken byte only matters once a packet has started
            if (frm != WAIT_AA) begin
                frm_nxt    = WAIT_AA;
                shadow_nxt = '0;
                abort_c    = 1'b1;
            end
        end else if (byte_rdy) begin
            case (frm)
                WAIT_AA: begin
                    if (byte_data == DELIM1) frm_nxt = WAIT_55;
                end
                WAIT_55: begin
                    if (byte_data == DELIM2) begin
                        frm_nxt = PAYLOAD;
                        idx_nxt = '0;
`ifdef TELEM_CHKSUM_EN
                        sum_nxt = '0;
`endif
                    end else if (byte_data != DELIM1) begin
                        frm_nxt = WAIT_AA;
                    end
                end
                PAYLOAD: begin
                    case (idx)
                        3'd0:    shadow_nxt.batt[11:8]   = byte_data[3:0];
                        3'd1:    shadow_nxt.batt[7:0]    = byte_data;
                        3'd2:    shadow_nxt.curr[11:8]   = byte_data[3:0];
                        3'd3:    shadow_nxt.curr[7:0]    = byte_data;
                        3'd4:    shadow_nxt.torque[11:8] = byte_data[3:0];
                        3'd5:    shadow_nxt.torque[7:0]  = byte_data;
                        default: ;
                    endcase
                    idx_nxt = idx + 3'd1;
`ifdef TELEM_CHKSUM_EN
                    sum_nxt = sum + byte_data;
                    if (idx == 3'(PAYLOAD_BYTES - 1)) frm_nxt = CHK;
`else
                    if (idx == 3'(PAYLOAD_BYTES - 1)) begin
                        frm_nxt  = WAIT_AA;
                        commit_c = 1'b1;
                    end
`endif
                end
`ifdef TELEM_CHKSUM_EN
                CHK: begin
                    frm_nxt = WAIT_AA;
                    if (byte_data == sum) commit_c = 1'b1;
                    else                  abort_c  = 1'b1;
                end
`endif
                default: frm_nxt = WAIT_AA;
            endcase
        end
    end

endmodule
